// File: rtl/ecu_boot_sequencer_pkg.sv
// Shared types and default timing for the PULPino boot sequencer.
package ecu_boot_pkg;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_PERIPH    = 3'd2,
    ST_CORE      = 3'd3,
    ST_FETCH     = 3'd4,
    ST_RUN       = 3'd5,
    ST_DRAIN     = 3'd6
  } boot_state_e;

  // Registered control outputs, one bit per reset/enable line.
  typedef struct packed {
    logic periph_rst_n;
    logic core_rst_n;
    logic fetch_en;
    logic boot_done;
  } boot_out_t;

  localparam int unsigned LOCK_FILT_DEFAULT    = 16;
  localparam int unsigned PERIPH_HOLD_DEFAULT  = 64;
  localparam int unsigned CORE_HOLD_DEFAULT    = 256;
  localparam int unsigned DRAIN_CYCLES_DEFAULT = 16;
  localparam int unsigned CNT_W_DEFAULT        = 16;
  localparam logic [31:0] BOOT_ADDR_DEFAULT    = 32'h0000_8000;

  // Output levels for a given state; the ordering periph -> core -> fetch
  // is encoded here so every state keeps the release chain intact.
  function automatic boot_out_t decode_outputs(input boot_state_e s);
    boot_out_t o;
    o = '0;
    case (s)
      ST_PERIPH, ST_CORE: begin
        o.periph_rst_n = 1'b1;
      end
      ST_FETCH, ST_DRAIN: begin
        o.periph_rst_n = 1'b1;
        o.core_rst_n   = 1'b1;
      end
      ST_RUN: begin
        o.periph_rst_n = 1'b1;
        o.core_rst_n   = 1'b1;
        o.fetch_en     = 1'b1;
        o.boot_done    = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/ecu_boot_sequencer_if.sv
// Control/status bundle between the boot sequencer and the ECU top.
interface ecu_boot_sequencer_if;

  logic        soft_rst_req_i;
  logic        fetch_hold_i;
  logic        periph_rst_no;
  logic        core_rst_no;
  logic        fetch_enable_o;
  logic [31:0] boot_addr_o;
  logic        boot_done_o;
  logic [2:0]  state_o;
  logic [7:0]  restart_cnt_o;

  modport master (
    input  soft_rst_req_i,
    input  fetch_hold_i,
    output periph_rst_no,
    output core_rst_no,
    output fetch_enable_o,
    output boot_addr_o,
    output boot_done_o,
    output state_o,
    output restart_cnt_o
  );

  modport slave (
    output soft_rst_req_i,
    output fetch_hold_i,
    input  periph_rst_no,
    input  core_rst_no,
    input  fetch_enable_o,
    input  boot_addr_o,
    input  boot_done_o,
    input  state_o,
    input  restart_cnt_o
  );

endinterface

// File: rtl/ecu_boot_sequencer_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level (PLL lock, switches, keys).
module ecu_sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic stage1_d, stage1_q;
  logic stage2_d, stage2_q;

  // Shift the raw input through two stages to settle metastability.
  always_comb begin
    stage1_d = d_i;
    stage2_d = stage1_q;
  end

  // Both stages clear to 0 so a locked PLL is never assumed out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage1_q <= 1'b0;
      stage2_q <= 1'b0;
    end else begin
      stage1_q <= stage1_d;
      stage2_q <= stage2_d;
    end
  end

  assign q_o = stage2_q;

endmodule

// File: rtl/ecu_boot_sequencer.sv
// Power-up / soft-restart sequencer: releases peripheral reset, core reset
// and fetch_enable in fixed order with programmable hold times.
module ecu_boot_sequencer
  import ecu_boot_pkg::*;
#(
  parameter int unsigned LOCK_FILT    = LOCK_FILT_DEFAULT,
  parameter int unsigned PERIPH_HOLD  = PERIPH_HOLD_DEFAULT,
  parameter int unsigned CORE_HOLD    = CORE_HOLD_DEFAULT,
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT,
  parameter int unsigned CNT_W        = CNT_W_DEFAULT,
  parameter logic [31:0] BOOT_ADDR    = BOOT_ADDR_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pll_locked_i,
  ecu_boot_sequencer_if.master bus
);

  // Terminal counts: a state of length N leaves on the edge where cnt == N-1.
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_FILT - 1);
  localparam logic [CNT_W-1:0] PERIPH_LAST = CNT_W'(PERIPH_HOLD - 1);
  localparam logic [CNT_W-1:0] CORE_LAST   = CNT_W'(CORE_HOLD - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_CYCLES - 1);

  logic             lock_s;
  boot_state_e      state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [7:0]       restart_cnt_d, restart_cnt_q;
  boot_out_t        out_d, out_q;
  logic             soft_accept;

  ecu_sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (pll_locked_i),
    .q_o   (lock_s)
  );

  // Next-state, hold counter and restart counter; lock loss beats everything.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + CNT_W'(1);
    restart_cnt_d = restart_cnt_q;
    soft_accept   = 1'b0;

    case (state_q)
      ST_RESET: begin
        state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (!lock_s) begin
          cnt_d = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = ST_PERIPH;
        end
      end
      ST_PERIPH: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == PERIPH_LAST) begin
          state_d = ST_CORE;
        end
      end
      ST_CORE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == CORE_LAST) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        cnt_d = cnt_q;
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (bus.soft_rst_req_i) begin
          state_d     = ST_DRAIN;
          soft_accept = 1'b1;
        end else if (!bus.fetch_hold_i) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q;
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (bus.soft_rst_req_i) begin
          state_d     = ST_DRAIN;
          soft_accept = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == DRAIN_LAST) begin
          state_d = ST_CORE;
        end
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end

    if (soft_accept && (restart_cnt_q != 8'hFF)) begin
      restart_cnt_d = restart_cnt_q + 8'd1;
    end

    out_d = decode_outputs(state_d);
  end

  // State, counters and decoded outputs all update on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RESET;
      cnt_q         <= '0;
      restart_cnt_q <= 8'd0;
      out_q         <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      restart_cnt_q <= restart_cnt_d;
      out_q         <= out_d;
    end
  end

  assign bus.periph_rst_no  = out_q.periph_rst_n;
  assign bus.core_rst_no    = out_q.core_rst_n;
  assign bus.fetch_enable_o = out_q.fetch_en;
  assign bus.boot_done_o    = out_q.boot_done;
  assign bus.boot_addr_o    = BOOT_ADDR;
  assign bus.state_o        = state_q;
  assign bus.restart_cnt_o  = restart_cnt_q;

endmodule

// File: tb/tb_ecu_boot_sequencer.sv
// Directed bench for the boot sequencer: table-driven boot timing plus
// hand-written lock-loss, hold, soft-restart and async-reset sequences.
module tb_ecu_boot_sequencer;

  logic clk;
  logic rst_n;
  logic pll_locked;

  int checks;
  int failures;

  ecu_boot_sequencer_if main_if ();
  ecu_boot_sequencer_if fast_if ();

  ecu_boot_sequencer u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pll_locked_i (pll_locked),
    .bus          (main_if)
  );

  // Short timings so the saturating restart counter can be exercised quickly.
  ecu_boot_sequencer #(
    .LOCK_FILT    (2),
    .PERIPH_HOLD  (2),
    .CORE_HOLD    (3),
    .DRAIN_CYCLES (2),
    .CNT_W        (4),
    .BOOT_ADDR    (32'h0000_8000)
  ) u_dut_fast (
    .clk          (clk),
    .rst_n        (rst_n),
    .pll_locked_i (pll_locked),
    .bus          (fast_if)
  );

  typedef struct {
    int         edge_num;
    logic [2:0] state;
    logic       periph;
    logic       core;
    logic       fetch;
    logic       done;
  } boot_vec_t;

  localparam int NVEC = 8;
  boot_vec_t boot_tbl [NVEC];

  // 100 MHz-style free-running clock; edges land at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic [2:0] st, input logic p, input logic c,
                            input logic f, input logic d);
    check_output({tag, "_state"},  32'(main_if.state_o),        32'(st));
    check_output({tag, "_periph"}, 32'(main_if.periph_rst_no),  32'(p));
    check_output({tag, "_core"},   32'(main_if.core_rst_no),    32'(c));
    check_output({tag, "_fetch"},  32'(main_if.fetch_enable_o), 32'(f));
    check_output({tag, "_done"},   32'(main_if.boot_done_o),    32'(d));
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_soft();
    main_if.soft_rst_req_i = 1'b1;
    tick(1);
    main_if.soft_rst_req_i = 1'b0;
  endtask

  // Hold reset two cycles, check reset values, release just after an edge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    main_if.soft_rst_req_i = 1'b0;
    fast_if.soft_rst_req_i = 1'b0;
    tick(2);
    check_outs({tag, "_rst"}, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_output({tag, "_rst_restart"}, 32'(main_if.restart_cnt_o), 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic run_boot_table(input string tag);
    int cur;
    cur = 0;
    for (int i = 0; i < NVEC; i++) begin
      tick(boot_tbl[i].edge_num - cur);
      cur = boot_tbl[i].edge_num;
      check_outs($sformatf("%s_e%0d", tag, boot_tbl[i].edge_num), boot_tbl[i].state,
                 boot_tbl[i].periph, boot_tbl[i].core, boot_tbl[i].fetch, boot_tbl[i].done);
    end
  endtask

  // Release-order invariant on both instances every cycle.
  always @(negedge clk) begin
    check_output("order_main",
                 32'((!main_if.fetch_enable_o || main_if.core_rst_no) &&
                     (!main_if.core_rst_no || main_if.periph_rst_no)), 32'd1);
    check_output("order_fast",
                 32'((!fast_if.fetch_enable_o || fast_if.core_rst_no) &&
                     (!fast_if.core_rst_no || fast_if.periph_rst_no)), 32'd1);
  end

  initial begin
    checks   = 0;
    failures = 0;
    boot_tbl[0] = '{1,   3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    boot_tbl[1] = '{17,  3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    boot_tbl[2] = '{18,  3'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    boot_tbl[3] = '{81,  3'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    boot_tbl[4] = '{82,  3'd3, 1'b1, 1'b0, 1'b0, 1'b0};
    boot_tbl[5] = '{337, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0};
    boot_tbl[6] = '{338, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0};
    boot_tbl[7] = '{339, 3'd5, 1'b1, 1'b1, 1'b1, 1'b1};

    rst_n                  = 1'b0;
    pll_locked             = 1'b1;
    main_if.soft_rst_req_i = 1'b0;
    main_if.fetch_hold_i   = 1'b0;
    fast_if.soft_rst_req_i = 1'b0;
    fast_if.fetch_hold_i   = 1'b0;

    $display("[TB] cold boot");
    do_reset("t1");
    check_output("boot_addr", main_if.boot_addr_o, 32'h0000_8000);
    run_boot_table("t1");

    $display("[TB] lock glitch in WAIT_LOCK and lock drop in RUN");
    do_reset("t2");
    tick(10);
    pll_locked = 1'b0;
    tick(3);
    pll_locked = 1'b1;
    tick(17);
    check_outs("t2_e30", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);
    check_outs("t2_e31", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(320);
    check_outs("t2_e351", 3'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(1);
    check_outs("t2_e352", 3'd5, 1'b1, 1'b1, 1'b1, 1'b1);
    pll_locked = 1'b0;
    tick(2);
    check_outs("t2_drop2", 3'd5, 1'b1, 1'b1, 1'b1, 1'b1);
    tick(1);
    check_outs("t2_drop3", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    pll_locked = 1'b1;
    run_boot_table("t2_reboot");

    $display("[TB] fetch hold");
    main_if.fetch_hold_i = 1'b1;
    do_reset("t3");
    tick(338);
    check_outs("t3_e338", 3'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(1000);
    check_outs("t3_held", 3'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    main_if.fetch_hold_i = 1'b0;
    tick(1);
    check_outs("t3_release", 3'd5, 1'b1, 1'b1, 1'b1, 1'b1);

    $display("[TB] soft restart");
    do_reset("t4");
    tick(30);
    pulse_soft();
    check_outs("t4_periph_pulse", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    check_output("t4_periph_cnt", 32'(main_if.restart_cnt_o), 32'd0);
    tick(69);
    pulse_soft();
    check_outs("t4_core_pulse", 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    check_output("t4_core_cnt", 32'(main_if.restart_cnt_o), 32'd0);
    tick(238);
    check_outs("t4_run", 3'd5, 1'b1, 1'b1, 1'b1, 1'b1);
    pulse_soft();
    check_outs("t4_drain_in", 3'd6, 1'b1, 1'b1, 1'b0, 1'b0);
    check_output("t4_cnt1", 32'(main_if.restart_cnt_o), 32'd1);
    tick(4);
    pulse_soft();
    check_outs("t4_drain_pulse", 3'd6, 1'b1, 1'b1, 1'b0, 1'b0);
    check_output("t4_drain_cnt", 32'(main_if.restart_cnt_o), 32'd1);
    tick(10);
    check_outs("t4_drain_last", 3'd6, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(1);
    check_outs("t4_core_in", 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(255);
    check_outs("t4_core_last", 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1);
    check_outs("t4_fetch", 3'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(1);
    check_outs("t4_rerun", 3'd5, 1'b1, 1'b1, 1'b1, 1'b1);
    check_output("t4_cnt_end", 32'(main_if.restart_cnt_o), 32'd1);

    $display("[TB] lock loss vs soft request, counter saturation");
    pll_locked = 1'b0;
    tick(2);
    main_if.soft_rst_req_i = 1'b1;
    tick(1);
    main_if.soft_rst_req_i = 1'b0;
    check_outs("t5_prio", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_output("t5_prio_cnt", 32'(main_if.restart_cnt_o), 32'd1);
    pll_locked = 1'b1;
    do_reset("t5");
    for (int i = 0; i < 300; i++) begin
      int c;
      c = 0;
      while (fast_if.state_o !== 3'd5 && c < 50) begin
        tick(1);
        c++;
      end
      if (fast_if.state_o !== 3'd5) begin
        check_output($sformatf("t5_wait_run_%0d", i), 32'(fast_if.state_o), 32'd5);
      end
      fast_if.soft_rst_req_i = 1'b1;
      tick(1);
      fast_if.soft_rst_req_i = 1'b0;
      if (i == 0 || i == 253 || i == 254 || i == 299) begin
        check_output($sformatf("t5_sat_%0d", i + 1), 32'(fast_if.restart_cnt_o),
                     (i >= 254) ? 32'd255 : 32'(i + 1));
      end
    end

    $display("[TB] async reset mid-DRAIN and mid-CORE");
    do_reset("t6a");
    tick(339);
    pulse_soft();
    check_output("t6_drain_cnt", 32'(main_if.restart_cnt_o), 32'd1);
    tick(3);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("t6_drain_async", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_output("t6_drain_restart", 32'(main_if.restart_cnt_o), 32'd0);
    do_reset("t6b");
    tick(100);
    check_outs("t6_core", 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("t6_core_async", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_output("t6_core_restart", 32'(main_if.restart_cnt_o), 32'd0);
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
